jtopl_acc: RTL and testbench



---
 rtl/jtopl_acc.sv | 104 ++++++++++
 tb/tb_jtopl_acc.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/jtopl_acc.sv
// Channel accumulator: sums audible operator outputs over an 18-slot frame and
// emits one saturated signed 16-bit sample per correctly framed sum.
module jtopl_acc #(
  parameter int SLOTS = 18,
  parameter int GAIN  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cenop,
  input  logic               zero,
  input  logic signed [13:0] op_result,
  input  logic               op_out,
  input  logic               con_out,
  output logic signed [15:0] snd,
  output logic               sample,
  output logic               locked
);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int SW = 19 + GAIN;
  localparam logic signed [SW-1:0] MAX16 = SW'(32767);
  localparam logic signed [SW-1:0] MIN16 = -SW'(32768);

  logic [0:0]         state;
  logic signed [18:0] acc;
  logic signed [18:0] contrib;
  logic [4:0]         cnt;
  logic [4:0]         cnt_next;
  logic               last_slot;
  logic signed [SW-1:0] shifted;
  logic signed [15:0] sat;

  // Modulators only reach the mix when the connection makes them additive.
  assign contrib   = (op_out | con_out) ? 19'(op_result) : '0;
  assign last_slot = (cnt == 5'(SLOTS - 1));

  // The counter never wraps on its own, so a missing zero is always detectable.
  always_comb begin
    cnt_next = cnt + 5'd1;
    if (zero)
      cnt_next = '0;
    else if (cnt >= 5'(SLOTS))
      cnt_next = 5'(SLOTS);
  end

  always_comb begin
    shifted = SW'(acc) <<< GAIN;
    sat     = shifted[15:0];
    if (shifted > MAX16)
      sat = 16'sh7fff;
    else if (shifted < MIN16)
      sat = -16'sh8000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HUNT;
      acc    <= '0;
      cnt    <= '0;
      snd    <= '0;
      sample <= 1'b0;
      locked <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (cenop) begin
        cnt <= cnt_next;
        case (state)
          HUNT: begin
            if (zero) begin
              acc    <= contrib;
              state  <= RUN;
              locked <= 1'b1;
            end
          end
          RUN: begin
            if (zero) begin
              // An early zero restarts the frame here but drops lock for one slot.
              acc    <= contrib;
              locked <= last_slot;
              if (last_slot) begin
                snd    <= sat;
                sample <= 1'b1;
              end
            end else if (last_slot) begin
              state  <= HUNT;
              acc    <= '0;
              locked <= 1'b0;
            end else begin
              acc    <= acc + contrib;
              locked <= 1'b1;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtopl_acc.sv
// Directed self-checking bench for jtopl_acc; a GAIN=2 copy runs alongside
// on the same stimulus to cover the pre-saturation shift.
module tb_jtopl_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cenop = 1'b0;
  logic zero = 1'b0;
  logic op_out = 1'b0;
  logic con_out = 1'b0;
  logic signed [13:0] op_result = '0;

  logic signed [15:0] snd;
  logic signed [15:0] snd_g2;
  logic sample, sample_g2, locked, locked_g2;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int pulses0 = 0;
  int gap = 0;
  int s_snd, s_sample, s_locked, s_snd_g2;

  jtopl_acc #(.SLOTS(18), .GAIN(0)) dut (
    .clk(clk), .rst(rst), .cenop(cenop), .zero(zero), .op_result(op_result),
    .op_out(op_out), .con_out(con_out), .snd(snd), .sample(sample), .locked(locked)
  );

  jtopl_acc #(.SLOTS(18), .GAIN(2)) dut_g2 (
    .clk(clk), .rst(rst), .cenop(cenop), .zero(zero), .op_result(op_result),
    .op_out(op_out), .con_out(con_out), .snd(snd_g2), .sample(sample_g2), .locked(locked_g2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sample) pulses++;

  task automatic check_output(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      $error("[TB] %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One enabled slot, snapshot the outputs, then optional disabled cycles with junk inputs.
  task automatic apply_stimulus(input logic z, input int val, input logic op, input logic con);
    zero = z;
    op_result = 14'(val);
    op_out = op;
    con_out = con;
    cenop = 1'b1;
    @(posedge clk);
    #1;
    s_snd = snd;
    s_sample = sample;
    s_locked = locked;
    s_snd_g2 = snd_g2;
    if (gap > 0) begin
      cenop = 1'b0;
      zero = 1'b1;
      op_result = 14'sd999;
      op_out = 1'b1;
      con_out = 1'b1;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_body(input int val, input logic op, input logic con,
                            input int n_active, input int n_slots);
    for (int i = 1; i <= n_slots; i++)
      apply_stimulus(1'b0, (i < n_active) ? val : 0, op, con);
  endtask

  initial begin
    #12;
    check_output("reset_snd", snd, 0);
    check_output("reset_sample", sample, 0);
    check_output("reset_locked", locked, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame of 18 x 100 carriers
    apply_stimulus(1'b1, 100, 1'b1, 1'b0);
    check_output("locked_after_first_zero", s_locked, 1);
    frame_body(100, 1'b1, 1'b0, 18, 17);
    check_output("no_pulse_before_frame_end", pulses, 0);
    apply_stimulus(1'b1, 500, 1'b0, 1'b0);
    check_output("basic_snd", s_snd, 1800);
    check_output("basic_sample", s_sample, 1);
    check_output("basic_locked", s_locked, 1);
    frame_body(500, 1'b0, 1'b0, 18, 1);
    check_output("sample_one_cycle", s_sample, 0);
    frame_body(500, 1'b0, 1'b0, 18, 16);
    check_output("single_pulse", pulses, 1);

    // Modulators without connection are silent, with connection they add
    apply_stimulus(1'b1, 500, 1'b0, 1'b1);
    check_output("modulator_silent", s_snd, 0);
    frame_body(500, 1'b0, 1'b1, 18, 17);
    apply_stimulus(1'b1, 8191, 1'b1, 1'b0);
    check_output("connected_mod", s_snd, 9000);
    frame_body(8191, 1'b1, 1'b0, 18, 17);
    apply_stimulus(1'b1, -8192, 1'b1, 1'b0);
    check_output("sat_positive", s_snd, 32767);
    frame_body(-8192, 1'b1, 1'b0, 18, 17);
    apply_stimulus(1'b1, 1000, 1'b1, 1'b0);
    check_output("sat_negative", s_snd, -32768);
    check_output("sat_negative_g2", s_snd_g2, -32768);
    frame_body(1000, 1'b1, 1'b0, 10, 17);
    apply_stimulus(1'b1, 800, 1'b1, 1'b0);
    check_output("partial_g0", s_snd, 10000);
    check_output("gain2_saturates", s_snd_g2, 32767);
    frame_body(800, 1'b1, 1'b0, 10, 17);

    // Early zero after cnt reaches 9
    apply_stimulus(1'b1, 100, 1'b1, 1'b0);
    check_output("gain0_8000", s_snd, 8000);
    check_output("gain2_unsaturated", s_snd_g2, 32000);
    frame_body(100, 1'b1, 1'b0, 18, 9);
    pulses0 = pulses;
    apply_stimulus(1'b1, 7, 1'b1, 1'b0);
    check_output("early_zero_no_sample", s_sample, 0);
    check_output("early_zero_snd_holds", s_snd, 8000);
    check_output("early_zero_unlocked", s_locked, 0);
    frame_body(7, 1'b1, 1'b0, 18, 1);
    check_output("relock_next_slot", s_locked, 1);
    frame_body(7, 1'b1, 1'b0, 18, 16);
    check_output("early_zero_no_pulse", pulses, pulses0);
    apply_stimulus(1'b1, 50, 1'b1, 1'b0);
    check_output("after_early_zero_snd", s_snd, 126);
    check_output("after_early_zero_sample", s_sample, 1);

    // Missing zero after slot 17
    frame_body(50, 1'b1, 1'b0, 18, 17);
    pulses0 = pulses;
    apply_stimulus(1'b0, 50, 1'b1, 1'b0);
    check_output("missing_zero_unlocked", s_locked, 0);
    check_output("missing_zero_snd_holds", s_snd, 126);
    check_output("missing_zero_no_sample", s_sample, 0);
    frame_body(50, 1'b1, 1'b0, 18, 3);
    check_output("hunt_stays_unlocked", s_locked, 0);
    apply_stimulus(1'b1, 20, 1'b1, 1'b0);
    check_output("hunt_no_sample_on_zero", s_sample, 0);
    frame_body(20, 1'b1, 1'b0, 18, 17);
    check_output("hunt_no_pulse", pulses, pulses0);
    apply_stimulus(1'b1, 0, 1'b1, 1'b0);
    check_output("resync_snd", s_snd, 360);
    check_output("resync_sample", s_sample, 1);

    // cenop at 1-in-4 with junk inputs on disabled cycles
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    gap = 3;
    apply_stimulus(1'b1, 100, 1'b1, 1'b0);
    frame_body(100, 1'b1, 1'b0, 18, 17);
    pulses0 = pulses;
    apply_stimulus(1'b1, 100, 1'b1, 1'b0);
    check_output("cen_snd", s_snd, 1800);
    check_output("cen_sample", s_sample, 1);
    check_output("cen_single_pulse", pulses, pulses0 + 1);
    check_output("cen_sample_dropped", sample, 0);

    // Asynchronous reset at slot 7
    frame_body(100, 1'b1, 1'b0, 18, 6);
    pulses0 = pulses;
    #2;
    rst = 1'b1;
    #1;
    check_output("midreset_snd", snd, 0);
    check_output("midreset_locked", locked, 0);
    check_output("midreset_sample", sample, 0);
    #10;
    rst = 1'b0;
    frame_body(100, 1'b1, 1'b0, 18, 12);
    check_output("midreset_no_stray_pulse", pulses, pulses0);
    check_output("midreset_stays_hunting", s_locked, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
